// File: rtl/uart_pkg.sv
// Shared types and derived-constant helpers for the UART packet receiver.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_e;

   // Clocks per oversampling tick.
   function automatic int calc_clk_per_samp(int clk_hz, int baud, int samp);
      return clk_hz / baud / samp;
   endfunction

   // Inter-frame timeout expressed in system clocks.
   function automatic int calc_timeout_cyc(int clk_hz, int timeout_ns);
      return (clk_hz / 1_000_000) * timeout_ns / 1000;
   endfunction

endpackage

// File: rtl/uart_pkt_rx_if.sv
// Packet output handshake between the receiver and its consumer.
//
// valid/ready: the producer raises valid_out with data_out and holds both
// stable until a cycle where valid_out and ready_in are both high; that cycle
// is the transfer. ready_in may change freely and never depends on valid_out
// combinationally on the producer side. A new packet may be loaded in the
// same cycle as a transfer, in which case valid_out stays high.
interface uart_pkt_rx_if #(
   parameter int W = 8
);
   logic [W-1:0] data_out;
   logic         valid_out;
   logic         ready_in;

   modport master (output data_out, output valid_out, input ready_in);
   modport slave  (input data_out, input valid_out, output ready_in);
endinterface

// File: rtl/uart_bit_rx.sv
// Frame-level UART receiver: synchroniser, oversampling tick, frame FSM and
// 3-sample majority vote. Emits one decoded data word per good frame.
module uart_bit_rx
   import uart_pkg::*;
#(
   parameter int SAMP_PER_BIT = 16,
   parameter int CLK_PER_SAMP = 651,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] byte_out,
   output logic                 byte_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output rx_state_e            state
);

   localparam int TICK_W = $clog2(CLK_PER_SAMP + 1);
   localparam int BT_W   = $clog2(SAMP_PER_BIT + 2);
   localparam int BI_W   = $clog2(DATA_BITS + 1);
   localparam parity_e PAR_MODE = parity_e'(PARITY);

   logic                 rx_m, rx_s, rx_q;
   logic [TICK_W-1:0]    tick_cnt;
   logic                 tick;
   logic [1:0]           hist;
   logic [BT_W-1:0]      bit_tick;
   logic [BI_W-1:0]      bit_idx;
   logic [DATA_BITS-1:0] data_sr;
   logic                 par_bad;
   logic                 vote;
   logic                 bit_done;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_q <= 1'b1;
      end else begin
         rx_m <= rx_in;
         rx_s <= rx_m;
         rx_q <= rx_s;
      end
   end

   // Free-running oversampling tick generator.
   always_ff @(posedge clk_in) begin
      if (rst_in) tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TICK_W'(1);
   end

   assign tick = (tick_cnt == TICK_W'(CLK_PER_SAMP - 1));

   // Last two tick samples; with the current sample they straddle the bit midpoint.
   always_ff @(posedge clk_in) begin
      if (rst_in) hist <= 2'b11;
      else if (tick) hist <= {hist[0], rx_s};
   end

   // bit_tick is zeroed at the start-bit midpoint, so a value of SAMP_PER_BIT
   // on a tick means "one tick past the next bit midpoint": hist[1], hist[0]
   // and rx_s are then the samples at mid-1, mid and mid+1.
   assign vote     = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
   assign bit_done = tick && (bit_tick == BT_W'(SAMP_PER_BIT));

   // Frame FSM with registered result/error pulses.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state      <= ST_IDLE;
         bit_tick   <= '0;
         bit_idx    <= '0;
         data_sr    <= '0;
         par_bad    <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         if (tick) bit_tick <= bit_tick + BT_W'(1);
         case (state)
            ST_IDLE: begin
               if (rx_q && !rx_s) begin
                  bit_tick <= '0;
                  bit_idx  <= '0;
                  par_bad  <= 1'b0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (tick && bit_tick == BT_W'(SAMP_PER_BIT / 2 - 1)) begin
                  if (rx_s) begin
                     state <= ST_IDLE;
                  end else begin
                     bit_tick <= '0;
                     state    <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  data_sr  <= {vote, data_sr[DATA_BITS-1:1]};
                  bit_tick <= BT_W'(1);
                  bit_idx  <= bit_idx + BI_W'(1);
                  if (bit_idx == BI_W'(DATA_BITS - 1))
                     state <= (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  bit_tick <= BT_W'(1);
                  if (vote != ((^data_sr) ^ (PAR_MODE == PAR_ODD))) par_bad <= 1'b1;
                  state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  if (!vote) begin
                     frame_err <= 1'b1;
                     bit_tick  <= '0;
                     state     <= ST_WAIT_IDLE;
                  end else if (par_bad) begin
                     parity_err <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     byte_out   <= data_sr;
                     byte_valid <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_IDLE: begin
               // Require one full bit of continuous high before re-arming.
               if (!rx_s) bit_tick <= '0;
               else if (tick && bit_tick == BT_W'(SAMP_PER_BIT - 1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_pkt_rx.sv
// UART packet receiver: assembles PKT_BYTES frames into one word, drops
// stale partial packets on timeout, and holds the result in a valid/ready
// output register.
module uart_pkt_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD_RATE    = 9600,
   parameter int SAMP_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int PKT_BYTES    = 21,
   parameter int TIMEOUT_NS   = 2_000_000,
   parameter int CLK_PER_SAMP = calc_clk_per_samp(CLK_HZ, BAUD_RATE, SAMP_PER_BIT),
   parameter int TIMEOUT_CYC  = calc_timeout_cyc(CLK_HZ, TIMEOUT_NS)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          rx_in,
   uart_pkt_rx_if.master pkt_if,
   output logic          frame_err_out,
   output logic          parity_err_out,
   output logic          timeout_out,
   output logic          overrun_out,
   output rx_state_e     rx_state_out
);

   localparam int WORD_W = PKT_BYTES * DATA_BITS;
   localparam int CNT_W  = $clog2(PKT_BYTES + 1);
   localparam int GAP_W  = $clog2(TIMEOUT_CYC + 1);

   logic [DATA_BITS-1:0] byte_data;
   logic                 byte_valid;
   logic                 frame_err;
   logic                 parity_err;
   rx_state_e            rx_state;
   logic [WORD_W-1:0]    pkt;
   logic [WORD_W-1:0]    pkt_next;
   logic [CNT_W-1:0]     byte_cnt;
   logic [GAP_W-1:0]     gap_cnt;
   logic                 last_byte;

   uart_bit_rx #(
      .SAMP_PER_BIT (SAMP_PER_BIT),
      .CLK_PER_SAMP (CLK_PER_SAMP),
      .DATA_BITS    (DATA_BITS),
      .PARITY       (PARITY)
   ) u_bit_rx (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rx_in      (rx_in),
      .byte_out   (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .state      (rx_state)
   );

   assign frame_err_out  = frame_err;
   assign parity_err_out = parity_err;
   assign rx_state_out   = rx_state;

   // Packet image with the incoming frame written into its slot.
   always_comb begin
      pkt_next = pkt;
      pkt_next[byte_cnt * DATA_BITS +: DATA_BITS] = byte_data;
   end

   assign last_byte = byte_valid && (byte_cnt == CNT_W'(PKT_BYTES - 1));

   // Packet assembly and inter-frame timeout.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pkt         <= '0;
         byte_cnt    <= '0;
         gap_cnt     <= '0;
         timeout_out <= 1'b0;
      end else begin
         timeout_out <= 1'b0;
         if (frame_err || parity_err) begin
            byte_cnt <= '0;
            gap_cnt  <= '0;
         end else if (byte_valid) begin
            pkt      <= pkt_next;
            gap_cnt  <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
         end else if (byte_cnt != '0 && rx_state == ST_IDLE) begin
            // Gap only accrues while waiting for the next start edge.
            if (gap_cnt == GAP_W'(TIMEOUT_CYC - 1)) begin
               timeout_out <= 1'b1;
               byte_cnt    <= '0;
               gap_cnt     <= '0;
            end else begin
               gap_cnt <= gap_cnt + GAP_W'(1);
            end
         end
      end
   end

   // Output register: load on completion if free or draining this cycle, else overrun.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pkt_if.data_out  <= '0;
         pkt_if.valid_out <= 1'b0;
         overrun_out      <= 1'b0;
      end else begin
         overrun_out <= 1'b0;
         if (last_byte) begin
            if (!pkt_if.valid_out || pkt_if.ready_in) begin
               pkt_if.data_out  <= pkt_next;
               pkt_if.valid_out <= 1'b1;
            end else begin
               overrun_out <= 1'b1;
            end
         end else if (pkt_if.valid_out && pkt_if.ready_in) begin
            pkt_if.valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: 96 MHz clock, 1 Mbaud, 16x oversampling, 8E1,
// three-frame packets, 20 us inter-frame timeout.
module tb_uart_pkt_rx;
   import uart_pkg::*;

   localparam int BIT_CLK = 96;
   localparam int W       = 24;

   logic      clk_in = 1'b0;
   logic      rst_in = 1'b1;
   logic      rx_in  = 1'b1;
   logic      frame_err_out, parity_err_out, timeout_out, overrun_out;
   rx_state_e rx_state_out;

   uart_pkt_rx_if #(.W(W)) pkt_if ();

   uart_pkt_rx #(
      .CLK_HZ       (96_000_000),
      .BAUD_RATE    (1_000_000),
      .SAMP_PER_BIT (16),
      .DATA_BITS    (8),
      .PARITY       (1),
      .PKT_BYTES    (3),
      .TIMEOUT_NS   (20_000)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rx_in          (rx_in),
      .pkt_if         (pkt_if),
      .frame_err_out  (frame_err_out),
      .parity_err_out (parity_err_out),
      .timeout_out    (timeout_out),
      .overrun_out    (overrun_out),
      .rx_state_out   (rx_state_out)
   );

   // Clock
   always #5 clk_in = ~clk_in;

   int         n_vec = 0;
   int         n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_pkt;
   int         n_valid_cyc, n_acc, n_frame, n_par, n_tmo, n_ovr;

   // Scoreboard / monitor: sample on the falling edge.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (pkt_if.valid_out) n_valid_cyc++;
         if (frame_err_out)    n_frame++;
         if (parity_err_out)   n_par++;
         if (timeout_out)      n_tmo++;
         if (overrun_out)      n_ovr++;
         if (pkt_if.valid_out && pkt_if.ready_in) begin
            n_acc++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL pkt_unexpected: got %h, required no packet", pkt_if.data_out);
            end else begin
               exp_pkt = exp_q.pop_front();
               if (pkt_if.data_out !== exp_pkt) begin
                  n_err++;
                  $display("FAIL pkt_data: got %h, required %h", pkt_if.data_out, exp_pkt);
               end
            end
         end
      end
   end

   // Driver helpers
   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx_in = b;
      wait_clk(BIT_CLK);
   endtask

   task automatic idle_bits(input int n);
      rx_in = 1'b1;
      wait_clk(n * BIT_CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit((^d) ^ bad_par);
      send_bit(!bad_stop);
      rx_in = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b0);
      idle_bits(1);
   endtask

   task automatic clear_counts();
      n_valid_cyc = 0; n_acc = 0; n_frame = 0; n_par = 0; n_tmo = 0; n_ovr = 0;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      rx_in  = 1'b1;
      pkt_if.ready_in = 1'b1;
      wait_clk(4);
      @(negedge clk_in);
      n_vec += 6;
      if (pkt_if.data_out !== 24'h0) begin n_err++; $display("FAIL rst_data: got %h, required 0", pkt_if.data_out); end
      if (pkt_if.valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", pkt_if.valid_out); end
      if ({frame_err_out, parity_err_out, timeout_out, overrun_out} !== 4'b0) begin
         n_err++; $display("FAIL rst_errs: got %b, required 0000", {frame_err_out, parity_err_out, timeout_out, overrun_out});
      end
      if (rx_state_out !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d, required %0d", rx_state_out, ST_IDLE); end
      if (n_acc !== 0) begin n_err++; $display("FAIL rst_acc: got %0d, required 0", n_acc); end
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL rst_queue: got %0d, required 0", exp_q.size()); end
      wait_clk(1);
      rst_in = 1'b0;
      idle_bits(2);
   endtask

   task automatic test_single_packet();
      clear_counts();
      exp_q.push_back(24'h0F3CA5);
      send_good(8'hA5);
      send_good(8'h3C);
      send_good(8'h0F);
      idle_bits(3);
      n_vec += 4;
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t1_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t1_acc: got %0d, required 1", n_acc); end
      if (n_valid_cyc !== 1) begin n_err++; $display("FAIL t1_valid_cycles: got %0d, required 1", n_valid_cyc); end
      if (n_frame + n_par + n_tmo + n_ovr !== 0) begin
         n_err++; $display("FAIL t1_errs: got %0d pulses, required 0", n_frame + n_par + n_tmo + n_ovr);
      end
   endtask

   task automatic test_parity_error();
      clear_counts();
      send_good(8'hA5);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle_bits(2);
      n_vec += 2;
      if (n_par !== 1) begin n_err++; $display("FAIL t2_parity: got %0d, required 1", n_par); end
      if (n_acc !== 0) begin n_err++; $display("FAIL t2_early_pkt: got %0d, required 0", n_acc); end
      exp_q.push_back(24'h332211);
      send_good(8'h11);
      send_good(8'h22);
      send_good(8'h33);
      idle_bits(3);
      n_vec += 3;
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t2_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t2_acc: got %0d, required 1", n_acc); end
      if (n_par + n_frame + n_tmo + n_ovr !== 1) begin
         n_err++; $display("FAIL t2_errs: got %0d pulses, required 1", n_par + n_frame + n_tmo + n_ovr);
      end
   endtask

   task automatic test_frame_error();
      clear_counts();
      send_good(8'h77);
      send_frame(8'h5A, 1'b0, 1'b1);
      idle_bits(3);
      n_vec += 3;
      if (n_frame !== 1) begin n_err++; $display("FAIL t3_frame: got %0d, required 1", n_frame); end
      if (n_valid_cyc !== 0) begin n_err++; $display("FAIL t3_valid: got %0d cycles, required 0", n_valid_cyc); end
      if (rx_state_out !== ST_IDLE) begin n_err++; $display("FAIL t3_recover: got state %0d, required %0d", rx_state_out, ST_IDLE); end
      exp_q.push_back(24'h030201);
      send_good(8'h01);
      send_good(8'h02);
      send_good(8'h03);
      idle_bits(3);
      n_vec += 3;
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t3_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t3_acc: got %0d, required 1", n_acc); end
      if (n_frame + n_par + n_tmo + n_ovr !== 1) begin
         n_err++; $display("FAIL t3_errs: got %0d pulses, required 1", n_frame + n_par + n_tmo + n_ovr);
      end
   endtask

   task automatic test_timeout();
      clear_counts();
      send_good(8'hDE);
      send_good(8'hAD);
      wait_clk(2500);
      n_vec += 2;
      if (n_tmo !== 1) begin n_err++; $display("FAIL t4_timeout: got %0d, required 1", n_tmo); end
      if (n_acc !== 0) begin n_err++; $display("FAIL t4_early_pkt: got %0d, required 0", n_acc); end
      exp_q.push_back(24'h42EFBE);
      send_good(8'hBE);
      send_good(8'hEF);
      send_good(8'h42);
      idle_bits(3);
      n_vec += 3;
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t4_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t4_acc: got %0d, required 1", n_acc); end
      if (n_tmo + n_frame + n_par + n_ovr !== 1) begin
         n_err++; $display("FAIL t4_errs: got %0d pulses, required 1", n_tmo + n_frame + n_par + n_ovr);
      end
   endtask

   task automatic test_overrun();
      clear_counts();
      pkt_if.ready_in = 1'b0;
      exp_q.push_back(24'h302010);
      send_good(8'h10);
      send_good(8'h20);
      send_good(8'h30);
      idle_bits(2);
      @(negedge clk_in);
      n_vec += 2;
      if (pkt_if.valid_out !== 1'b1) begin n_err++; $display("FAIL t5_held_valid: got %b, required 1", pkt_if.valid_out); end
      if (pkt_if.data_out !== 24'h302010) begin n_err++; $display("FAIL t5_held_data: got %h, required 302010", pkt_if.data_out); end
      send_good(8'h40);
      send_good(8'h50);
      send_good(8'h60);
      idle_bits(2);
      @(negedge clk_in);
      n_vec += 4;
      if (n_ovr !== 1) begin n_err++; $display("FAIL t5_overrun: got %0d, required 1", n_ovr); end
      if (pkt_if.data_out !== 24'h302010) begin n_err++; $display("FAIL t5_kept_data: got %h, required 302010", pkt_if.data_out); end
      if (pkt_if.valid_out !== 1'b1) begin n_err++; $display("FAIL t5_kept_valid: got %b, required 1", pkt_if.valid_out); end
      if (n_acc !== 0) begin n_err++; $display("FAIL t5_early_acc: got %0d, required 0", n_acc); end
      wait_clk(1);
      pkt_if.ready_in = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      n_vec += 3;
      if (pkt_if.valid_out !== 1'b0) begin n_err++; $display("FAIL t5_drain_valid: got %b, required 0", pkt_if.valid_out); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t5_acc: got %0d, required 1", n_acc); end
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t5_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      wait_clk(1);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      clear_counts();
      d = 8'h56;
      send_good(8'h12);
      send_good(8'h34);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      rx_in = d[3];
      wait_clk(BIT_CLK / 2);
      rx_in  = 1'b1;
      rst_in = 1'b1;
      wait_clk(1);
      rst_in = 1'b0;
      @(negedge clk_in);
      n_vec += 4;
      if (pkt_if.data_out !== 24'h0) begin n_err++; $display("FAIL t6_rst_data: got %h, required 0", pkt_if.data_out); end
      if (pkt_if.valid_out !== 1'b0) begin n_err++; $display("FAIL t6_rst_valid: got %b, required 0", pkt_if.valid_out); end
      if ({frame_err_out, parity_err_out, timeout_out, overrun_out} !== 4'b0) begin
         n_err++; $display("FAIL t6_rst_errs: got %b, required 0000", {frame_err_out, parity_err_out, timeout_out, overrun_out});
      end
      if (rx_state_out !== ST_IDLE) begin n_err++; $display("FAIL t6_rst_state: got %0d, required %0d", rx_state_out, ST_IDLE); end
      wait_clk(1);
      idle_bits(4);
      // Two-sample low glitch while idle.
      rx_in = 1'b0;
      wait_clk(12);
      idle_bits(3);
      exp_q.push_back(24'hDEBC9A);
      send_good(8'h9A);
      send_good(8'hBC);
      send_good(8'hDE);
      idle_bits(3);
      n_vec += 3;
      if (exp_q.size() !== 0) begin n_err++; $display("FAIL t6_missing: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
      if (n_acc !== 1) begin n_err++; $display("FAIL t6_acc: got %0d, required 1", n_acc); end
      if (n_frame + n_par + n_tmo + n_ovr !== 0) begin
         n_err++; $display("FAIL t6_errs: got %0d pulses, required 0", n_frame + n_par + n_tmo + n_ovr);
      end
   endtask

   // Sequence and final report
   initial begin
      pkt_if.ready_in = 1'b1;
      clear_counts();
      test_reset();
      test_single_packet();
      test_parity_error();
      test_frame_error();
      test_timeout();
      test_overrun();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
